router_pkt_tx: RTL



---
 rtl/router_pkg.sv | 18 +
 rtl/router_tx_fifo.sv | 60 ++++++
 rtl/router_pkt_tx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter, bench and monitor.
package router_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {IDLE, LOAD, WAIT, DA, SA, LEN, PAY, CSUM, GAP} tx_state_e;

    localparam int HDR_BYTES = 3;
    localparam int DA_OFS    = 0;
    localparam int SA_OFS    = 1;
    localparam int LEN_OFS   = 2;

    // A command is framed only for 1..max_len payload bytes.
    function automatic logic len_ok(input byte_t len, input int max_len);
        return (len != 8'd0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/router_tx_fifo.sv
// Synchronous byte FIFO; pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module router_tx_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] wr_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    byte_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage is deliberately not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a whole payload, then emits DA, SA, LEN, payload as one
// gap-free frame. Define ROUTER_TX_CSUM_EN to append a trailing XOR checksum byte.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN    = 64,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_da,
    input  logic [7:0]       cmd_sa,
    input  logic [7:0]       cmd_len,
    input  logic [7:0]       pl_data,
    input  logic             pl_valid,
    output logic             pl_ready,
    input  logic             busy,
    output logic [7:0]       dut_inp,
    output logic             inp_valid,
    output logic             err_len,
    output logic [CNT_W-1:0] pkt_cnt
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_e     state;
    byte_t         da_q;
    byte_t         sa_q;
    byte_t         len_q;
    byte_t         cnt;
    byte_t         fifo_rd;
    logic [GW-1:0] gap_cnt;
    logic          fifo_empty;
    logic          fifo_full;
    logic          cmd_hs;
    logic          accept;
    logic          pop;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign accept = pl_valid && pl_ready && !fifo_full;
    assign pop    = (state == PAY) && !fifo_empty;

    router_tx_fifo #(.DEPTH(MAX_LEN)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .wr_data (pl_data),
        .pop     (pop),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

`ifdef ROUTER_TX_CSUM_EN
    byte_t csum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
        end else if (state == IDLE && cmd_hs) begin
            csum <= cmd_da ^ cmd_sa ^ cmd_len;
        end else if (accept) begin
            csum <= csum ^ pl_data;
        end
    end
`endif

    // Outputs are registered from the current state, so each byte appears one edge after its state is entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            pl_ready  <= 1'b0;
            dut_inp   <= '0;
            inp_valid <= 1'b0;
            err_len   <= 1'b0;
            pkt_cnt   <= '0;
            da_q      <= '0;
            sa_q      <= '0;
            len_q     <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
        end else begin
            err_len <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_hs) begin
                        cmd_ready <= 1'b0;
                        da_q      <= cmd_da;
                        sa_q      <= cmd_sa;
                        len_q     <= cmd_len;
                        cnt       <= '0;
                        if (len_ok(cmd_len, MAX_LEN)) begin
                            state    <= LOAD;
                            pl_ready <= 1'b1;
                        end else begin
                            err_len <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        cnt <= cnt + 8'd1;
                        if (cnt == len_q - 8'd1) begin
                            pl_ready <= 1'b0;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!busy) state <= DA;
                end
                DA: begin
                    dut_inp   <= da_q;
                    inp_valid <= 1'b1;
                    state     <= SA;
                end
                SA: begin
                    dut_inp <= sa_q;
                    state   <= LEN;
                end
                LEN: begin
                    dut_inp <= len_q;
                    cnt     <= '0;
                    state   <= PAY;
                end
                PAY: begin
                    dut_inp <= fifo_rd;
                    cnt     <= cnt + 8'd1;
                    if (cnt == len_q - 8'd1) begin
`ifdef ROUTER_TX_CSUM_EN
                        state <= CSUM;
`else
                        state   <= GAP;
                        gap_cnt <= '0;
                        pkt_cnt <= pkt_cnt + CNT_W'(1);
`endif
                    end
                end
`ifdef ROUTER_TX_CSUM_EN
                CSUM: begin
                    dut_inp <= csum;
                    state   <= GAP;
                    gap_cnt <= '0;
                    pkt_cnt <= pkt_cnt + CNT_W'(1);
                end
`endif
                GAP: begin
                    inp_valid <= 1'b0;
                    dut_inp   <= '0;
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
